// File: rtl/elev_beep_pkg.sv
// Shared types and constants for the elevator buzzer pattern sequencer.
// Pattern codes, FSM states, burst counts and small constant helpers.
package elev_beep_pkg;

  typedef enum logic [1:0] {
    BEEP_NONE   = 2'd0,
    BEEP_CLICK  = 2'd1,
    BEEP_ARRIVE = 2'd2,
    BEEP_ALARM  = 2'd3
  } beep_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } beep_state_e;

  localparam logic [1:0] BURSTS_CLICK  = 2'd1;
  localparam logic [1:0] BURSTS_ARRIVE = 2'd2;
  localparam logic [1:0] BURSTS_ALARM  = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Number of bursts in a pattern; NONE never leaves IDLE so 0 is harmless.
  function automatic logic [1:0] burst_count(input beep_code_e c);
    logic [1:0] n;
    case (c)
      BEEP_CLICK:  n = BURSTS_CLICK;
      BEEP_ARRIVE: n = BURSTS_ARRIVE;
      BEEP_ALARM:  n = BURSTS_ALARM;
      default:     n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/elev_beep_seq_if.sv
// 4-phase req/ack beep-request channel between the 100 ms control logic
// (master) and the buzzer sequencer (slave).
interface elev_beep_seq_if;
  logic       req_i;
  logic [1:0] code_i;
  logic       ack_o;

  modport master (output req_i, output code_i, input ack_o);
  modport slave  (input req_i, input code_i, output ack_o);
endinterface

// File: rtl/beep_req_sync.sv
// Two-flop synchroniser bringing the asynchronous beep request into clk_beep.
// Synchronous active-high reset clears both stages.
module beep_req_sync (
  input  logic clk_beep,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_beep) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/elev_beep_seq.sv
// Buzzer pattern sequencer: accepts beep requests over a 4-phase handshake and
// plays CLICK/ARRIVE/ALARM tone bursts. Define BEEP_PREEMPT_EN to let ALARM preempt.
//
// state  | meaning
// S_IDLE | silent, waiting for a request to accept
// S_ON   | tone burst playing
// S_OFF  | silent gap between bursts
module elev_beep_seq
  import elev_beep_pkg::*;
#(
  parameter int TONE_HALF = 1,
  parameter int ON_CYC    = 100,
  parameter int OFF_CYC   = 100,
  parameter int CLICK_CYC = 20
) (
  input  logic            clk_beep,
  input  logic            rst,
  elev_beep_seq_if.slave  bus,
  input  logic            mute_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            beep_o
);

  localparam int PW = $clog2(max3(ON_CYC, OFF_CYC, CLICK_CYC) + 1);
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [PW-1:0] ON_LAST    = PW'(ON_CYC - 1);
  localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_CYC - 1);
  localparam logic [PW-1:0] CLICK_LAST = PW'(CLICK_CYC - 1);
  localparam logic [TW-1:0] TONE_RLD   = TW'(TONE_HALF - 1);

  beep_state_e   state_q, state_d;
  beep_code_e    code_q, code_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    burst_q, burst_d;
  logic          tone_q, tone_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;

  logic          req_s;
  beep_code_e    req_code;
  logic [PW-1:0] burst_last;
  logic          last_burst;
  logic          accept_idle;
  logic          accept_pre;
  logic          accept;

  beep_req_sync u_sync (
    .clk_beep (clk_beep),
    .rst      (rst),
    .d_i      (bus.req_i),
    .q_o      (req_s)
  );

  assign req_code = beep_code_e'(bus.code_i);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    phase_d = phase_q;
    burst_d = burst_q;
    tone_d  = tone_q;
    tcnt_d  = tcnt_q;
    ack_d   = ack_q;
    done_d  = 1'b0;

    burst_last  = (code_q == BEEP_CLICK) ? CLICK_LAST : ON_LAST;
    last_burst  = (burst_q == (burst_count(code_q) - 2'd1));
    accept_idle = req_s && !ack_q && (state_q == S_IDLE);
`ifdef BEEP_PREEMPT_EN
    accept_pre  = req_s && !ack_q && (state_q != S_IDLE) &&
                  (req_code == BEEP_ALARM) && (code_q != BEEP_ALARM);
`else
    accept_pre  = 1'b0;
`endif
    accept      = accept_idle || accept_pre;

    // Release follows req_s alone so playback never stalls the requester.
    if (ack_q && !req_s) ack_d = 1'b0;

    case (state_q)
      S_ON: begin
        if (tcnt_q == '0) begin
          tone_d = ~tone_q;
          tcnt_d = TONE_RLD;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
        if (phase_q == burst_last) begin
          phase_d = '0;
          if (last_burst) begin
            state_d = S_IDLE;
            burst_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_OFF;
            burst_d = burst_q + 2'd1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_OFF: begin
        if (phase_q == OFF_LAST) begin
          state_d = S_ON;
          phase_d = '0;
          tone_d  = 1'b1;
          tcnt_d  = TONE_RLD;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A preempting accept overrides whatever the running pattern was doing.
    if (accept) begin
      ack_d  = 1'b1;
      code_d = req_code;
      done_d = 1'b0;
      if (req_code != BEEP_NONE) begin
        state_d = S_ON;
        phase_d = '0;
        burst_d = '0;
        tone_d  = 1'b1;
        tcnt_d  = TONE_RLD;
      end
    end
  end

  always_ff @(posedge clk_beep) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= BEEP_NONE;
      phase_q <= '0;
      burst_q <= '0;
      tone_q  <= 1'b0;
      tcnt_q  <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      phase_q <= phase_d;
      burst_q <= burst_d;
      tone_q  <= tone_d;
      tcnt_q  <= tcnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign bus.ack_o = ack_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign beep_o    = (state_q == S_ON) && tone_q && !mute_i;

endmodule

// File: doc/elev_beep_seq.md
# elev_beep_seq

Buzzer pattern sequencer for the two-floor elevator controller. It is the responder end of a 4-phase req/ack beep-request interface. The 100 ms control logic raises a request carrying a pattern code. This block synchronises the request into the clk_beep domain, acknowledges it and plays the selected pattern of tone bursts on the buzzer pin. It replaces ad-hoc beep toggling in the controller with one timed, arbitrated output.

## Interface
- TONE_HALF, 1: clk_beep cycles per tone half-period. With the 500 Hz clk_beep this gives 250 Hz at 50 % duty.
- ON_CYC, 100: burst length for ARRIVE/ALARM, in cycles (200 ms).
- OFF_CYC, 100: gap between bursts, in cycles.
- CLICK_CYC, 20: burst length for CLICK (40 ms).
- clk_beep  in  1  buzzer-domain clock, 500 Hz.
- rst  in  1  reset: synchronous, active-high, on clk_beep. It must be held at least 1 clk_beep edge.
- req_i  in  1  beep request from the 100 ms domain. It is asynchronous to clk_beep.
- code_i  in  2  pattern code. The requester keeps it stable while req_i=1.
- mute_i  in  1  forces beep_o=0. Sequence timing is unaffected.
- ack_o  out  1  handshake acknowledge.
- busy_o  out  1  a pattern is playing.
- done_o  out  1  one-cycle pulse when a pattern completes.
- beep_o  out  1  buzzer drive.

## Operation
- **Pattern codes:**
  - 0 NONE: acknowledged, silent, no busy.
  - 1 CLICK: 1 burst of CLICK_CYC.
  - 2 ARRIVE: 2 bursts of ON_CYC.
  - 3 ALARM: 3 bursts of ON_CYC.
  - Bursts are separated by OFF_CYC. There is no gap after the last burst.
- **Request synchronisation:** req_i passes through a 2-flop synchroniser to give req_s.
- **Accept condition:** req_s=1, ack_o=0, and state=IDLE.
- **On accept:**
  - code_i is latched.
  - ack_o goes to 1.
  - For codes 1–3, the state goes to ON, busy_o=1, the burst counter is cleared and the phase counter is cleared.
- **Release:** ack_o falls on the first edge that samples req_s=0 while ack_o=1. This happens independently of the pattern state, so the requester is never stalled by playback.
- **Pending request:** a request arriving while busy stays pending with ack_o low. It is accepted on the first IDLE cycle.
- **FSM states:**
  - IDLE → ON on accept of codes 1–3.
  - ON → OFF after the burst length, if bursts remain.
  - ON → IDLE after the last burst, with done_o=1 for one cycle and busy_o=0.
  - OFF → ON after OFF_CYC.
- **Tone generation:** in ON, beep_o starts at 1 and toggles every TONE_HALF cycles. beep_o=0 in IDLE and OFF, and whenever mute_i=1.
- **Code 0:** the handshake completes, with no busy and no done pulse.
- **Counter widths:**
  - Phase counter width is $clog2(max(ON_CYC,OFF_CYC,CLICK_CYC)+1).
  - The burst counter is 2 bits.
  - No counter wraps: each terminal count forces a state change.
- **Reset (including mid-pattern):**
  - state=IDLE and all counters=0.
  - ack_o=0, busy_o=0, done_o=0, beep_o=0.
  - Synchroniser flops are cleared.
  - After reset, a still-high req_i is treated as a new request.

## Timing
- **Request latency:** req_i rises before edge E0; req_s=1 after E1. The accept happens at E2, after which ack_o=1, busy_o=1 and beep_o=1.
- **Burst length:** each burst keeps the state in ON for exactly its burst-length cycles, counted from the first beep_o=1 cycle.
- **ARRIVE, total busy:** 2·ON_CYC+OFF_CYC cycles, which is 300 cycles = 600 ms at the defaults.
- **ALARM, total busy:** 3·ON_CYC+2·OFF_CYC cycles = 500 cycles.
- **done_o:** asserted in the cycle after the final ON cycle.
- **Simultaneous done and pending request:** the pending request is accepted on the next edge, so there is 1 IDLE cycle between patterns.
- **ack_o fall latency:** 3 edges after req_i falls (2 sync + 1 register).

## Configuration
- **BEEP_PREEMPT_EN defined:**
  - A pending code-3 request is accepted while busy, provided the current pattern is not ALARM.
  - On this accept, ack_o rises and the ALARM pattern restarts from its first ON cycle with beep_o=1.
  - The aborted pattern produces no done_o pulse.
- **BEEP_PREEMPT_EN undefined:** every request waits for IDLE.

## Structure
- Package elev_beep_pkg holds:
  - the code enum (BEEP_NONE, BEEP_CLICK, BEEP_ARRIVE, BEEP_ALARM);
  - the state enum (S_IDLE, S_ON, S_OFF);
  - the burst-count constants (1/2/3).
- One sub-module, beep_req_sync: a 2-flop synchroniser with synchronous active-high reset.

## Test plan
- **CLICK:** code=1 req pulse held until ack → ack high 3 edges after req, beep_o toggles 1,0,1… for 20 cycles → done_o pulse → busy_o low.
- **ARRIVE:** code=2 → 100 cycles of toggling, 100 cycles of 0, 100 cycles of toggling → done_o at cycle 301 after accept.
- **Queued request:** a second ARRIVE request issued during the first → ack stays 0 until IDLE → accepted 1 cycle after done_o.
- **Mute and code 0:** mute_i=1 during ALARM → beep_o=0 throughout, but done_o still at cycle 501. code=0 → ack toggles, busy_o stays 0.
- **Reset mid-pattern:** rst mid-burst in ARRIVE → next cycle beep_o, ack_o and busy_o are 0. A held req_i is re-accepted 3 edges after rst falls.
- **BEEP_PREEMPT_EN:** ALARM requested 50 cycles into ARRIVE → with the macro, ALARM starts at once and there is no ARRIVE done_o. Without the macro, ALARM starts 1 cycle after ARRIVE done_o.
